// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and widths for the 16-bit ALU issuer
package alu_pkg;
  localparam int SLICE_W = 8;
  localparam int WORD_W = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
  // Only ADD/SUB chain a carry/borrow between slices and report carry-out
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction
endpackage

// File: rtl/alu16_issuer.sv
// alu16_issuer: issues 16-bit ops to an external 8-bit ALU as low/high byte slices
module alu16_issuer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WORD_W-1:0]  req_a,
  input  logic [WORD_W-1:0]  req_b,
  input  logic               req_cin,
  input  logic [2:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_s,
  output logic               rsp_cout,
  output logic               rsp_zero,
  output logic [SLICE_W-1:0] alu_a,
  output logic [SLICE_W-1:0] alu_b,
  output logic               alu_cin,
  output logic [2:0]         alu_op,
  input  logic [SLICE_W-1:0] alu_s,
  input  logic               alu_cout
);
  state_t r_state, w_next;
  logic [WORD_W-1:0] r_a, r_b, r_s;
  logic [2:0] r_op;
  logic r_cin, r_carry, r_cout, r_zero;
  logic w_arith, w_lo_ph, w_hi_ph;
  logic [SLICE_W-1:0] w_lo, w_hi;

  assign w_arith = is_arith(r_op);
  assign w_lo_ph = r_state == LO;
  assign w_hi_ph = r_state == HI;
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_s = r_s;
  assign rsp_cout = r_cout;
  assign rsp_zero = r_zero;
  assign alu_a = w_lo_ph ? r_a[7:0] : w_hi_ph ? r_a[15:8] : '0;
  assign alu_b = w_lo_ph ? r_b[7:0] : w_hi_ph ? r_b[15:8] : '0;
  assign alu_op = (w_lo_ph || w_hi_ph) ? r_op : '0;
  assign alu_cin = w_lo_ph ? (w_arith & r_cin) : w_hi_ph ? (w_arith & r_carry) : 1'b0;
  // Shift bits crossing the byte boundary are patched in when the high slice lands
  assign w_hi = {alu_s[7:1], alu_s[0] | ((r_op == OP_SHL) & r_a[7])};
  assign w_lo = {r_s[7] | ((r_op == OP_SHR) & r_a[8]), r_s[6:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Next-state: IDLE -> LO -> HI -> RESP -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = req_valid ? LO : IDLE;
      LO: w_next = HI;
      HI: w_next = RESP;
      RESP: w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-slice result capture and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_cin <= 1'b0;
      r_carry <= 1'b0;
      r_s <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      if (req_ready && req_valid) begin
        r_a <= req_a;
        r_b <= req_b;
        r_op <= req_op;
        r_cin <= req_cin;
      end
      if (w_lo_ph) begin
        r_s[7:0] <= alu_s;
        r_carry <= alu_cout;
      end
      if (w_hi_ph) begin
        r_s <= {w_hi, w_lo};
        r_cout <= w_arith & alu_cout;
        r_zero <= ~|{w_hi, w_lo};
      end
    end
  end
endmodule

// File: tb/tb_alu16_issuer.sv
// tb_alu16_issuer: directed + random checks of the issuer driving a behavioural 8-bit ALU
module tb_alu16_issuer;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_cin = 0, rsp_valid, rsp_ready = 0, rsp_cout, rsp_zero;
  logic [15:0] req_a = 0, req_b = 0, rsp_s;
  logic [2:0] req_op = 0, alu_op;
  logic [7:0] alu_a, alu_b, alu_s;
  logic alu_cin, alu_cout;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu16_issuer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout)
  );

  // The team's 8-bit ALU: slice shifts fill with zero, carry-out is the bit shifted off
  always_comb begin
    alu_s = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000: {alu_cout, alu_s} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      3'b001: {alu_cout, alu_s} = 9'(alu_a) - 9'(alu_b) - 9'(alu_cin);
      3'b010: alu_s = alu_a & alu_b;
      3'b011: alu_s = alu_a | alu_b;
      3'b100: alu_s = alu_a ^ alu_b;
      3'b101: alu_s = ~alu_a;
      3'b110: {alu_cout, alu_s} = {alu_a, 1'b0};
      default: {alu_s, alu_cout} = {1'b0, alu_a};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: 16-bit arithmetic straight from the operation rules
  task automatic model(input logic [2:0] op, input logic [15:0] a, b, input logic cin,
                       output logic [15:0] s, output logic c);
    logic [16:0] t;
    t = 17'h0;
    case (op)
      3'd0: t = 17'(a) + 17'(b) + 17'(cin);
      3'd1: t = 17'(a) - 17'(b) - 17'(cin);
      3'd2: t = {1'b0, a & b};
      3'd3: t = {1'b0, a | b};
      3'd4: t = {1'b0, a ^ b};
      3'd5: t = {1'b0, ~a};
      3'd6: t = {1'b0, a << 1};
      default: t = {1'b0, a >> 1};
    endcase
    s = t[15:0];
    c = (op <= 3'd1) ? t[16] : 1'b0;
  endtask

  // One request through the pipe; hold = cycles of rsp backpressure, keep = leave req_valid high
  task automatic run(input logic [2:0] op, input logic [15:0] a, b, input logic cin,
                     input int hold, input bit keep);
    logic [15:0] es;
    logic ec, lc;
    bit ar;
    model(op, a, b, cin, es, ec);
    ar = op <= 3'd1;
    lc = (op == 3'd0) ? (9'(a[7:0]) + 9'(b[7:0]) + 9'(cin)) > 9'd255
                      : (9'(a[7:0]) < 9'(b[7:0]) + 9'(cin));
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = keep;
    chk("lo_alu", {alu_a, alu_b, 5'(alu_op), 1'(alu_cin), 10'd0},
        {a[7:0], b[7:0], 5'(op), 1'(ar & cin), 10'd0});
    chk("lo_busy", {30'd0, req_ready, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("hi_alu", {alu_a, alu_b, 5'(alu_op), 1'(alu_cin), 10'd0},
        {a[15:8], b[15:8], 5'(op), 1'(ar & lc), 10'd0});
    chk("hi_busy", {30'd0, req_ready, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_s", 32'(rsp_s), 32'(es));
    chk("rsp_flags", {30'd0, rsp_cout, rsp_zero}, {30'd0, ec, es == 16'h0});
    chk("resp_alu_idle", {alu_a, alu_b, 5'(alu_op), 1'(alu_cin), 10'd0}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {req_ready, rsp_valid, 14'd0, rsp_s}, {1'b0, 1'b1, 14'd0, es});
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    logic [15:0] es;
    logic ec;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst_ports", {req_ready, rsp_valid, rsp_cout, rsp_zero, 12'd0, rsp_s}, {4'b1001, 28'd0});
    chk("rst_alu", {alu_a, alu_b, 5'(alu_op), 1'(alu_cin), 10'd0}, 32'd0);
    run(3'd0, 16'h12FF, 16'h0001, 0, 0, 0);
    run(3'd0, 16'hFFFF, 16'h0001, 0, 0, 0);
    run(3'd1, 16'h1000, 16'h0001, 0, 0, 0);
    run(3'd1, 16'h0000, 16'h0001, 0, 0, 0);
    run(3'd6, 16'h80C1, 16'h1234, 1, 0, 0);
    run(3'd7, 16'h0180, 16'hFFFF, 1, 0, 0);
    run(3'd5, 16'h00F0, 16'h0000, 0, 0, 0);
    run(3'd4, 16'hAAAA, 16'h0F0F, 0, 0, 0);
    // Backpressure with a pending request: exactly one acceptance after the handshake
    run(3'd0, 16'h4321, 16'h1111, 1, 5, 1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model(3'd0, 16'h4321, 16'h1111, 1, es, ec);
    chk("bp_second_rsp", {15'd0, rsp_valid, es}, {15'd0, 1'b1, 16'h5433});
    chk("bp_second_s", 32'(rsp_s), 32'(es));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_no_extra", {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    // Reset while the high slice is being issued
    req_op = 3'd0; req_a = 16'h7777; req_b = 16'h1111; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("in_hi", 32'(alu_a), 32'h77);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst_hi_ports", {req_ready, rsp_valid, rsp_cout, rsp_zero, 12'd0, rsp_s}, {4'b1001, 28'd0});
    chk("rst_hi_alu", {alu_a, alu_b, 5'(alu_op), 1'(alu_cin), 10'd0}, 32'd0);
    rsp_ready = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("aborted_silent", {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    rsp_ready = 0;
    run(3'd0, 16'h0001, 16'h0001, 0, 0, 0);
    for (int k = 0; k < 40; k++)
      run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), k % 3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
